// File: rtl/flit_input_arbiter_pkg.sv
// Shared flit types and arbiter enumerations for the NoC input stage.
// Payload carries opaque data; only flittype is interpreted by the arbiter.
package types;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flittype_t;

  localparam int unsigned PAYLOAD_W = 30;

  typedef struct packed {
    flittype_t              flittype;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOCK_CPU  = 2'b01,
    LOCK_LINK = 2'b10
  } arb_state_t;

  typedef enum logic {
    CPU  = 1'b0,
    LINK = 1'b1
  } src_t;

  function automatic logic is_start(flittype_t t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

  function automatic src_t other_src(src_t s);
    return (s == CPU) ? LINK : CPU;
  endfunction

endpackage

// File: rtl/flit_input_arbiter_if.sv
// Bundle of the arbiter's source, sink and error signals.
// master = surrounding fabric (sources, packet controller); slave = arbiter.
interface flit_input_arbiter_if;

  types::flit_t cpu_flit_in;
  logic         cpu_flit_valid;
  logic         cpu_flit_ready;
  types::flit_t link_flit_in;
  logic         link_flit_valid;
  logic         link_flit_ready;
  types::flit_t flit_out;
  logic         flit_out_valid;
  logic         flit_out_ready;
  logic         proto_error;
  logic         timeout_error;

  modport master (
    output cpu_flit_in, cpu_flit_valid, input cpu_flit_ready,
    output link_flit_in, link_flit_valid, input link_flit_ready,
    input  flit_out, flit_out_valid, output flit_out_ready,
    input  proto_error, timeout_error
  );

  modport slave (
    input  cpu_flit_in, cpu_flit_valid, output cpu_flit_ready,
    input  link_flit_in, link_flit_valid, output link_flit_ready,
    output flit_out, flit_out_valid, input flit_out_ready,
    output proto_error, timeout_error
  );

endinterface

// File: rtl/flit_input_arbiter_output_reg.sv
// Single-entry valid/ready register stage; loads only when slot_free,
// so the held flit is stable while downstream backpressures.
module flit_output_reg
  import types::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  flit_t in_flit,
  input  logic  in_load,
  output logic  slot_free,
  output flit_t out_flit,
  output logic  out_valid,
  input  logic  out_ready
);

  flit_t flit_q, flit_d;
  logic  valid_q, valid_d;

  assign slot_free = !valid_q || out_ready;
  assign out_flit  = flit_q;
  assign out_valid = valid_q;

  always_comb begin
    flit_d  = flit_q;
    valid_d = valid_q;
    if (in_load) begin
      flit_d  = in_flit;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flit_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      flit_q  <= flit_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/flit_input_arbiter.sv
// Wormhole arbiter merging CPU and link flits into one registered stream,
// with packet-granular round-robin, orphan dropping and a lock watchdog.
module flit_input_arbiter
  import types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 nocclk,
  input  logic                 rst_n,
  flit_input_arbiter_if.slave  bus
);

  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t      state_q, state_d;
  src_t            rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            proto_error_q, proto_error_d;
  logic            timeout_error_q, timeout_error_d;

  logic  slot_free;
  src_t  grant;
  logic  grant_valid;
  flit_t grant_flit;
  logic  accept;
  logic  load;

  // rr_ptr_q names the source that wins the next tie; after a packet
  // completes it is pointed at the source that did not just own the output.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    wd_cnt_d        = wd_cnt_q;
    proto_error_d   = 1'b0;
    timeout_error_d = 1'b0;
    grant           = rr_ptr_q;
    grant_valid     = 1'b0;
    accept          = 1'b0;
    load            = 1'b0;

    case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (bus.cpu_flit_valid && bus.link_flit_valid) begin
          grant       = rr_ptr_q;
          grant_valid = 1'b1;
        end else if (bus.cpu_flit_valid) begin
          grant       = CPU;
          grant_valid = 1'b1;
        end else if (bus.link_flit_valid) begin
          grant       = LINK;
          grant_valid = 1'b1;
        end
      end
      LOCK_CPU, LOCK_LINK: begin
        grant       = (state_q == LOCK_CPU) ? CPU : LINK;
        grant_valid = (grant == CPU) ? bus.cpu_flit_valid : bus.link_flit_valid;
      end
      default: state_d = IDLE;
    endcase

    grant_flit = (grant == CPU) ? bus.cpu_flit_in : bus.link_flit_in;

    if (state_q == IDLE) begin
      if (grant_valid) begin
        if (!is_start(grant_flit.flittype)) begin
          accept        = 1'b1;
          proto_error_d = 1'b1;
        end else if (slot_free) begin
          accept = 1'b1;
          load   = 1'b1;
          if (grant_flit.flittype == HEAD)
            state_d = (grant == CPU) ? LOCK_CPU : LOCK_LINK;
          else
            rr_ptr_d = other_src(grant);
        end
      end
    end else if (state_q == LOCK_CPU || state_q == LOCK_LINK) begin
      if (grant_valid) begin
        // a backpressured owner neither ages nor resets the watchdog
        if (slot_free) begin
          accept   = 1'b1;
          load     = 1'b1;
          wd_cnt_d = '0;
          case (grant_flit.flittype)
            TAIL: begin
              state_d  = IDLE;
              rr_ptr_d = other_src(grant);
            end
            HEAD: proto_error_d = 1'b1;
            HEADTAIL: begin
              proto_error_d = 1'b1;
              state_d       = IDLE;
              rr_ptr_d      = other_src(grant);
            end
            default: ;
          endcase
        end
      end else if (wd_cnt_q == WD_LAST) begin
        state_d         = IDLE;
        timeout_error_d = 1'b1;
        wd_cnt_d        = '0;
        rr_ptr_d        = other_src(grant);
      end else if (wd_cnt_q != '1) begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
  end

  assign bus.cpu_flit_ready  = accept && (grant == CPU);
  assign bus.link_flit_ready = accept && (grant == LINK);
  assign bus.proto_error     = proto_error_q;
  assign bus.timeout_error   = timeout_error_q;

  flit_output_reg u_out_reg (
    .clk       (nocclk),
    .rst_n     (rst_n),
    .in_flit   (grant_flit),
    .in_load   (load),
    .slot_free (slot_free),
    .out_flit  (bus.flit_out),
    .out_valid (bus.flit_out_valid),
    .out_ready (bus.flit_out_ready)
  );

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= LINK;
      wd_cnt_q        <= '0;
      proto_error_q   <= 1'b0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      wd_cnt_q        <= wd_cnt_d;
      proto_error_q   <= proto_error_d;
      timeout_error_q <= timeout_error_d;
    end
  end

endmodule
